// File: rtl/dot_map_scanner.sv
// Serial dot counter for the 144-bit dot map: snapshots on frame_start, counts one bit per clock,
// then awards points for dots eaten since the previous scan and flags level clear.
module dot_map_scanner #(
    parameter int POINTS  = 10,
    parameter int SCORE_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic               clear_score,
    input  logic [143:0]       dot_display,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         dots_left,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               dot_eaten,
    output logic               level_clear
);

    localparam int WIDE = SCORE_W + 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [143:0]         snapshot_q, snapshot_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           acc_q, acc_d;
    logic [7:0]           prev_count_q, prev_count_d;
    logic                 first_scan_q, first_scan_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           dots_left_q, dots_left_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 eaten_q, eaten_d;
    logic                 level_clear_q, level_clear_d;

    logic [7:0]           diff;
    logic [WIDE-1:0]      product;
    logic [WIDE:0]        sum;
    logic [SCORE_W-1:0]   score_sat;

    // Award arithmetic is done wide so the saturation test sees every carry.
    assign diff      = prev_count_q - acc_q;
    assign product   = WIDE'(diff) * WIDE'(POINTS);
    assign sum       = (WIDE+1)'(score_q) + (WIDE+1)'(product);
    assign score_sat = (sum[WIDE:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d       = state_q;
        snapshot_d    = snapshot_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        prev_count_d  = prev_count_q;
        first_scan_d  = first_scan_q;
        score_d       = score_q;
        dots_left_d   = dots_left_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        eaten_d       = 1'b0;
        level_clear_d = level_clear_q;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    snapshot_d = dot_display;
                    idx_d      = 8'd143;
                    acc_d      = 8'd0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q + {7'd0, snapshot_q[idx_q]};
                idx_d = idx_q - 8'd1;
                if (idx_q == 8'd0) state_d = UPDATE;
            end
            UPDATE: begin
                dots_left_d   = acc_q;
                prev_count_d  = acc_q;
                level_clear_d = (acc_q == 8'd0);
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
                if (first_scan_q) begin
                    first_scan_d = 1'b0;
                end else if (acc_q < prev_count_q) begin
                    score_d = score_sat;
                    eaten_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear wins over the award of a coinciding UPDATE, but the rest of the update stands.
        if (clear_score) begin
            score_d      = '0;
            first_scan_d = 1'b1;
            eaten_d      = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            snapshot_q    <= '0;
            idx_q         <= 8'd0;
            acc_q         <= 8'd0;
            prev_count_q  <= 8'd0;
            first_scan_q  <= 1'b1;
            score_q       <= '0;
            dots_left_q   <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            eaten_q       <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            snapshot_q    <= snapshot_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            prev_count_q  <= prev_count_d;
            first_scan_q  <= first_scan_d;
            score_q       <= score_d;
            dots_left_q   <= dots_left_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            eaten_q       <= eaten_d;
            level_clear_q <= level_clear_d;
        end
    end

    assign score       = score_q;
    assign dots_left   = dots_left_q;
    assign scan_busy   = busy_q;
    assign scan_done   = done_q;
    assign dot_eaten   = eaten_q;
    assign level_clear = level_clear_q;

endmodule
